// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code decoder: tracks F0/E0 prefixes, emits one-cycle media
// command pulses for selected make codes, and tracks the held key.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses pulses for
// keyboard auto-repeat (repeated make of the held key).
module ps2_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       next_song,
    output logic       pre_song,
    output logic       vol_add,
    output logic       vol_sub,
    output logic       stop,
    output logic       start,
    output logic [7:0] last_code,
    output logic       key_held
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    // Command vector order: next_song, pre_song, vol_add, vol_sub, stop, start
    function automatic logic [5:0] cmd_map(input logic [7:0] code);
        logic [5:0] cmd;
        cmd = 6'b000000;
        case (code)
            8'h05:   cmd = 6'b100000;
            8'h06:   cmd = 6'b010000;
            8'h04:   cmd = 6'b001000;
            8'h0C:   cmd = 6'b000100;
            8'h03:   cmd = 6'b000010;
            8'h0B:   cmd = 6'b000001;
            default: cmd = 6'b000000;
        endcase
        return cmd;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       cmd_q, cmd_d;
    logic [7:0]       last_code_q, last_code_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             key_held_q, key_held_d;
    logic             repeat_c;

    // Auto-repeat detection: same make code while the key is still down
`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeat_c = key_held_q && (rx_data == held_code_q);
`else
    assign repeat_c = 1'b0;
`endif

    // State register and tracked key/command state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            last_code_q <= 8'h00;
            held_code_q <= 8'h00;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            last_code_q <= last_code_d;
            held_code_q <= held_code_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state, prefix timeout and command decode; a byte on the expiry
    // cycle wins over the timeout because rx_valid is examined first
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = 6'b000000;
        last_code_d = last_code_q;
        held_code_d = held_code_q;
        key_held_d  = key_held_q;

        if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        last_code_d = rx_data;
                        held_code_d = rx_data;
                        key_held_d  = 1'b1;
                        if (!repeat_c) begin
                            cmd_d = cmd_map(rx_data);
                        end
                    end
                end
                ST_BRK: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                        if (rx_data == held_code_q) begin
                            key_held_d = 1'b0;
                        end
                    end
                end
                ST_EXT: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign next_song = cmd_q[5];
    assign pre_song  = cmd_q[4];
    assign vol_add   = cmd_q[3];
    assign vol_sub   = cmd_q[2];
    assign stop      = cmd_q[1];
    assign start     = cmd_q[0];
    assign last_code = last_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: directed scenarios plus a
// randomized byte stream compared against a prefix/gap-based reference model.
// Honours PS2_TYPEMATIC_FILTER_EN in the same way as the design build.
module tb_ps2_cmd_decoder;

    localparam int unsigned T = 16;

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       next_song, pre_song, vol_add, vol_sub, stop, start;
    logic [7:0] last_code;
    logic       key_held;
    logic [5:0] obs_cmd;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: pending prefix flags and idle-gap counter
    bit         m_brk, m_ext;
    int         m_idle;
    logic [7:0] m_last, m_held;
    logic       m_kh;
    logic [5:0] m_cmd;

    ps2_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .next_song(next_song), .pre_song(pre_song), .vol_add(vol_add),
        .vol_sub(vol_sub), .stop(stop), .start(start),
        .last_code(last_code), .key_held(key_held)
    );

    assign obs_cmd = {next_song, pre_song, vol_add, vol_sub, stop, start};

    always #5 clk = ~clk;

    function automatic logic [5:0] expect_cmd(input logic [7:0] b);
        case (b)
            8'h05:   return 6'b100000;
            8'h06:   return 6'b010000;
            8'h04:   return 6'b001000;
            8'h0C:   return 6'b000100;
            8'h03:   return 6'b000010;
            8'h0B:   return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_idle = 0;
        m_last = 8'h00; m_held = 8'h00; m_kh = 1'b0; m_cmd = 6'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        m_cmd = 6'b0;
        if (v) begin
            m_idle = 0;
            if (d == 8'hF0) begin
                if (m_ext && !m_brk) m_brk = 1;
                else begin m_ext = 0; m_brk = 1; end
            end else if (d == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else begin
                if (!m_brk && !m_ext) begin
                    if (!(FILTER && m_kh && d == m_held)) m_cmd = expect_cmd(d);
                    m_last = d; m_held = d; m_kh = 1'b1;
                end else if (m_brk && !m_ext) begin
                    if (d == m_held) m_kh = 1'b0;
                end
                m_brk = 0; m_ext = 0;
            end
        end else if (m_brk || m_ext) begin
            m_idle++;
            if (m_idle >= int'(T)) begin
                m_brk = 0; m_ext = 0; m_idle = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance model, sample 1 ns after the edge
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        model_step(v, d);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_cmd !== 6'b0) begin n_fail++; $display("FAIL reset_cmd: got %b want 000000", obs_cmd); end
        n_cmp++;
        if (last_code !== 8'h00) begin n_fail++; $display("FAIL reset_last: got %h want 00", last_code); end
        n_cmp++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_make();
        do_reset();
        step(1'b1, 8'h05);
        n_cmp++;
        if (obs_cmd !== 6'b100000) begin n_fail++; $display("FAIL basic_pulse: got %b want 100000", obs_cmd); end
        n_cmp++;
        if (last_code !== 8'h05) begin n_fail++; $display("FAIL basic_last: got %h want 05", last_code); end
        n_cmp++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL basic_held: got %b want 1", key_held); end
        step(1'b0, 8'h00);
        n_cmp++;
        if (obs_cmd !== 6'b0) begin n_fail++; $display("FAIL basic_pulse_len: got %b want 000000", obs_cmd); end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [5];
        int pulses;
        seq = '{8'h0C, 8'h0C, 8'h0C, 8'hF0, 8'h0C};
        pulses = 0;
        do_reset();
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            if (vol_sub === 1'b1) pulses++;
        end
        step(1'b0, 8'h00);
        n_cmp++;
        if (pulses !== (FILTER ? 1 : 3)) begin
            n_fail++; $display("FAIL typematic_count: got %0d want %0d", pulses, FILTER ? 1 : 3);
        end
        n_cmp++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL typematic_release: got %b want 0", key_held); end
    endtask

    task automatic test_break_only();
        do_reset();
        step(1'b1, 8'h05);
        step(1'b1, 8'hF0);
        step(1'b1, 8'h03);
        n_cmp++;
        if (obs_cmd !== 6'b0) begin n_fail++; $display("FAIL break_nopulse: got %b want 000000", obs_cmd); end
        n_cmp++;
        if (last_code !== 8'h05) begin n_fail++; $display("FAIL break_last: got %h want 05", last_code); end
        n_cmp++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL break_mismatch_held: got %b want 1", key_held); end
        step(1'b1, 8'h06);
        n_cmp++;
        if (obs_cmd !== 6'b010000) begin n_fail++; $display("FAIL break_then_idle: got %b want 010000", obs_cmd); end
    endtask

    task automatic test_extended();
        logic [7:0] seq [5];
        seq = '{8'hE0, 8'h05, 8'hE0, 8'hF0, 8'h05};
        do_reset();
        step(1'b1, 8'h04);
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            n_cmp++;
            if (obs_cmd !== 6'b0) begin n_fail++; $display("FAIL ext_nopulse[%0d]: got %b want 000000", i, obs_cmd); end
        end
        n_cmp++;
        if (last_code !== 8'h04) begin n_fail++; $display("FAIL ext_last: got %h want 04", last_code); end
        step(1'b1, 8'h06);
        n_cmp++;
        if (obs_cmd !== 6'b010000) begin n_fail++; $display("FAIL ext_follow: got %b want 010000", obs_cmd); end
        n_cmp++;
        if (last_code !== 8'h06) begin n_fail++; $display("FAIL ext_follow_last: got %h want 06", last_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b1, 8'h05);
        step(1'b1, 8'hF0);
        for (int i = 0; i < int'(T); i++) step(1'b0, 8'h00);
        step(1'b1, 8'h0B);
        n_cmp++;
        if (obs_cmd !== 6'b000001) begin n_fail++; $display("FAIL timeout_make: got %b want 000001", obs_cmd); end
        n_cmp++;
        if (last_code !== 8'h0B) begin n_fail++; $display("FAIL timeout_last: got %h want 0B", last_code); end
        step(1'b1, 8'hF0);
        for (int i = 0; i < int'(T) - 1; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h0B);
        n_cmp++;
        if (obs_cmd !== 6'b0) begin n_fail++; $display("FAIL timeout_edge_pulse: got %b want 000000", obs_cmd); end
        n_cmp++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL timeout_edge_break: got %b want 0", key_held); end
    endtask

    task automatic test_reset_mid_prefix();
        do_reset();
        step(1'b1, 8'h05);
        step(1'b1, 8'hE0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({obs_cmd, last_code, key_held} !== 15'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b/%h/%b want all 0", obs_cmd, last_code, key_held);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b1, 8'h04);
        n_cmp++;
        if (obs_cmd !== 6'b001000) begin n_fail++; $display("FAIL midreset_first: got %b want 001000", obs_cmd); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int gap, r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 8))
                0: b = 8'h03; 1: b = 8'h04; 2: b = 8'h05; 3: b = 8'h06;
                4: b = 8'h0B; 5: b = 8'h0C; 6: b = 8'hF0; 7: b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            r = int'($urandom_range(0, 9));
            gap = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(1, 5)) : int'($urandom_range(12, 20));
            for (int g = 0; g <= gap; g++) begin
                if (g == 0) step(1'b1, b);
                else step(1'b0, 8'h00);
                n_cmp++;
                if (obs_cmd !== m_cmd) begin n_fail++; $display("FAIL rand_cmd #%0d: got %b want %b", n, obs_cmd, m_cmd); end
                n_cmp++;
                if (last_code !== m_last) begin n_fail++; $display("FAIL rand_last #%0d: got %h want %h", n, last_code, m_last); end
                n_cmp++;
                if (key_held !== m_kh) begin n_fail++; $display("FAIL rand_held #%0d: got %b want %b", n, key_held, m_kh); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_make();
        test_typematic();
        test_break_only();
        test_extended();
        test_timeout();
        test_reset_mid_prefix();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_decoder.md
PS2_CMD_DECODER -- requirements
Module: ps2_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000000, prefix-byte timeout in clk cycles (100 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_valid  input  1  one-cycle strobe, received PS/2 byte on rx_data.
REQ-005 SHALL have port rx_data  input  8  received PS/2 scan byte.
REQ-006 SHALL have ports next_song, pre_song, vol_add, vol_sub, stop, start  output  1 each  one-cycle command pulses.
REQ-007 SHALL have port last_code  output  8  most recent accepted non-extended make code.
REQ-008 SHALL have port key_held  output  1  high while a tracked make code has no matching break yet.

Function
REQ-009 SHALL run FSM states IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); all transitions occur only on rx_valid, except the timeout in REQ-015.
REQ-010 IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, stay IDLE.
REQ-011 BRK: next byte is a break code -> IDLE; if it equals held_code, clear key_held.
REQ-012 EXT: F0 -> EXT_BRK; other byte is an extended make -> IDLE, ignored (no pulse, last_code unchanged). EXT_BRK: next byte -> IDLE, ignored.
REQ-013 Command map for make codes in IDLE: 05 -> next_song, 06 -> pre_song, 04 -> vol_add, 0C -> vol_sub, 03 -> stop, 0B -> start.
REQ-014 Make code in IDLE: last_code <= byte, held_code <= byte, key_held <= 1, all on the clock edge after rx_valid. A mapped code asserts its pulse exactly 1 cycle after the rx_valid cycle, for exactly 1 cycle. At most one pulse is high in any cycle.
REQ-015 Timeout counter SHALL clear on every rx_valid and count while in BRK, EXT or EXT_BRK; on reaching TIMEOUT_CYCLES-1 with no rx_valid, the FSM returns to IDLE with no other effect.
REQ-016 rx_valid in the same cycle as timeout expiry: the byte is processed in the current state; the timeout is discarded.
REQ-017 F0 or E0 received in BRK, EXT_BRK, or as the second E0 in EXT: treated as a resync; F0 -> BRK, E0 -> EXT.
REQ-018 A break code that does not match held_code leaves key_held and held_code unchanged.
REQ-019 rx_valid low: state, outputs and held_code hold; pulses stay 0.

Reset
REQ-020 reset SHALL asynchronously force the state to IDLE, the timeout counter to 0, all pulses to 0, last_code to 00, held_code to 00 and key_held to 0, including during a prefix sequence.
REQ-021 First rx_valid after reset release SHALL be decoded from IDLE.

Configuration
REQ-022 Macro PS2_TYPEMATIC_FILTER_EN defined: a make code equal to held_code while key_held=1 (keyboard auto-repeat) SHALL produce no pulse; last_code is still updated.
REQ-023 PS2_TYPEMATIC_FILTER_EN undefined: every make code produces its pulse per REQ-014, regardless of key_held.

Verification
REQ-024 Reset, then byte 05 -> next_song high exactly 1 cycle, one cycle after rx_valid; last_code=05, key_held=1.
REQ-025 Bytes 0C, 0C, 0C, F0, 0C -> filter on: one vol_sub pulse; filter off: three pulses; key_held=0 at end in both cases.
REQ-026 Bytes F0, 03 -> no stop pulse; state IDLE; last_code unchanged.
REQ-027 Bytes E0, 05 and E0, F0, 05 -> no pulses, last_code unchanged; a following 06 gives one pre_song pulse.
REQ-028 Byte F0, then idle for TIMEOUT_CYCLES (use 16 in the bench) -> IDLE; then 0B -> start pulse. Repeat with 0B arriving on the expiry cycle -> treated as a break code, no pulse.
REQ-029 Assert reset between E0 and the next byte -> all outputs 0, state IDLE; after release, 04 -> vol_add pulse.
